// File: rtl/io_intr_sched_if.sv
// Signal bundle between the I/O flag logic / CPU and the interrupt scheduler.
// The slave modport is the scheduler's view; the master modport drives its inputs.
interface io_intr_sched_if;
   logic [1:0] fgi;
   logic [1:0] fgo;
   logic [3:0] imsk;
   logic       ien;
   logic       intr_ack;
   logic       insn_end;
   logic       intr_req;
   logic [1:0] src_id;
   logic       iot;
   logic       busy;
   logic       svc_done;
   logic       svc_tmo;

   modport slave (
      input  fgi, fgo, imsk, ien, intr_ack, insn_end,
      output intr_req, src_id, iot, busy, svc_done, svc_tmo
   );

   modport master (
      output fgi, fgo, imsk, ien, intr_ack, insn_end,
      input  intr_req, src_id, iot, busy, svc_done, svc_tmo
   );
endinterface

// File: rtl/io_intr_sched.sv
// Round-robin interrupt scheduler for the GPIO and UART I/O channels.
// Optional service-window timeout enabled by defining IO_INTR_TIMEOUT_EN.
module io_intr_sched #(
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = 12
) (
   input  logic            clk,
   input  logic            reset,
   io_intr_sched_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

   state_t           state, state_nx;
   logic [3:0]       pend;
   logic [1:0]       last, last_nx;
   logic [1:0]       src, src_nx;
   logic [1:0]       win;
   logic             win_vld;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             req, req_nx;
   logic             done, done_nx;
   logic             tmo, tmo_nx;
   logic             svc_end;
   logic             tmo_hit;

   // Returns {found, index}; scans last+1, last+2, ... and keeps the nearest hit.
   function automatic logic [2:0] rr_pick(input logic [3:0] p, input logic [1:0] l);
      logic [2:0] r;
      logic [1:0] idx;
      r = '0;
      for (int i = 4; i >= 1; i--) begin
         idx = l + 2'(i);
         if (p[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   assign pend           = {bus.fgo[1], bus.fgi[1], bus.fgo[0], bus.fgi[0]} & bus.imsk;
   assign {win_vld, win} = rr_pick(pend, last);
   assign svc_end        = ~pend[src] & bus.insn_end;

`ifdef IO_INTR_TIMEOUT_EN
   assign tmo_hit = (cnt == CNT_W'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign tmo_hit        = 1'b0;
   assign unused_timeout = (TIMEOUT > 0);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         req   <= 1'b0;
         src   <= 2'd0;
         last  <= 2'd3;
         cnt   <= '0;
         done  <= 1'b0;
         tmo   <= 1'b0;
      end else begin
         state <= state_nx;
         req   <= req_nx;
         src   <= src_nx;
         last  <= last_nx;
         cnt   <= cnt_nx;
         done  <= done_nx;
         tmo   <= tmo_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.ien && win_vld) state_nx = REQ;
         REQ: begin
            // An ack on the same edge as a withdraw condition takes priority.
            if (bus.intr_ack)              state_nx = SVC;
            else if (!pend[src] || !bus.ien) state_nx = IDLE;
         end
         SVC:     if (svc_end || tmo_hit) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      req_nx  = req;
      src_nx  = src;
      last_nx = last;
      cnt_nx  = cnt;
      done_nx = 1'b0;
      tmo_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.ien && win_vld) begin
               req_nx = 1'b1;
               src_nx = win;
            end
         end
         REQ: begin
            if (bus.intr_ack) begin
               req_nx = 1'b0;
               cnt_nx = '0;
            end else if (!pend[src] || !bus.ien) begin
               req_nx = 1'b0;
            end
         end
         SVC: begin
            cnt_nx = (&cnt) ? cnt : cnt + CNT_W'(1);
            // Completion outranks timeout; both rotate priority past this source.
            if (svc_end) begin
               done_nx = 1'b1;
               last_nx = src;
            end else if (tmo_hit) begin
               tmo_nx  = 1'b1;
               last_nx = src;
            end
         end
         default: req_nx = 1'b0;
      endcase
   end

   assign bus.intr_req = req;
   assign bus.src_id   = src;
   assign bus.iot      = src[1];
   assign bus.busy     = (state != IDLE);
   assign bus.svc_done = done;
   assign bus.svc_tmo  = tmo;

endmodule

// File: tb/tb_io_intr_sched.sv
// Self-checking bench for io_intr_sched: directed scenarios plus random stimulus
// compared each cycle against a behavioural model of the scheduling rules.
module tb_io_intr_sched;
   localparam int TO = 8;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;

   io_intr_sched_if bus ();

   io_intr_sched #(.TIMEOUT(TO), .CNT_W(12)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: phase 0 = nothing outstanding, 1 = request raised, 2 = being serviced.
   int         m_phase;
   logic       m_req;
   logic [1:0] m_src;
   logic [1:0] m_last;
   int         m_cnt;
   logic       m_done;
   logic       m_tmo;

   function automatic bit src_active(int s);
      bit f;
      case (s)
         0:       f = bus.fgi[0];
         1:       f = bus.fgo[0];
         2:       f = bus.fgi[1];
         default: f = bus.fgo[1];
      endcase
      return f && bus.imsk[s];
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_req   = 1'b0;
      m_src   = 2'd0;
      m_last  = 2'd3;
      m_cnt   = 0;
      m_done  = 1'b0;
      m_tmo   = 1'b0;
   endtask

   task automatic model_step();
      bit fin;
      bit expired;
      int s;
      m_done = 1'b0;
      m_tmo  = 1'b0;
      case (m_phase)
         0: begin
            if (bus.ien) begin
               for (int k = 1; k <= 4; k++) begin
                  s = (int'(m_last) + k) % 4;
                  if (src_active(s)) begin
                     m_src   = 2'(s);
                     m_req   = 1'b1;
                     m_phase = 1;
                     break;
                  end
               end
            end
         end
         1: begin
            if (bus.intr_ack) begin
               m_phase = 2;
               m_req   = 1'b0;
               m_cnt   = 0;
            end else if (!src_active(int'(m_src)) || !bus.ien) begin
               m_phase = 0;
               m_req   = 1'b0;
            end
         end
         default: begin
            fin     = !src_active(int'(m_src)) && bus.insn_end;
            expired = 1'b0;
`ifdef IO_INTR_TIMEOUT_EN
            expired = (m_cnt == TO - 1);
`endif
            if (m_cnt < 4095) m_cnt++;
            if (fin) begin
               m_phase = 0;
               m_done  = 1'b1;
               m_last  = m_src;
            end else if (expired) begin
               m_phase = 0;
               m_tmo   = 1'b1;
               m_last  = m_src;
            end
         end
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("intr_req", 32'(bus.intr_req), 32'(m_req));
      chk("src_id",   32'(bus.src_id),   32'(m_src));
      chk("iot",      32'(bus.iot),      32'(m_src[1]));
      chk("busy",     32'(bus.busy),     32'(m_phase != 0));
      chk("svc_done", 32'(bus.svc_done), 32'(m_done));
      chk("svc_tmo",  32'(bus.svc_tmo),  32'(m_tmo));
   endtask

   task automatic cycle();
      @(posedge clk);
      if (reset) model_reset();
      else       model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      repeat (2) cycle();
      reset = 1'b0;
   endtask

   task automatic set_src(input int s, input logic v);
      case (s)
         0:       bus.fgi[0] = v;
         1:       bus.fgo[0] = v;
         2:       bus.fgi[1] = v;
         default: bus.fgo[1] = v;
      endcase
   endtask

   task automatic wait_req(input int max);
      int n;
      n = 0;
      while (bus.intr_req !== 1'b1 && n < max) begin
         cycle();
         n++;
      end
      chk("wait_req", 32'(bus.intr_req), 32'd1);
   endtask

   initial begin
      int order[5];
      int n;
      order = '{0, 1, 2, 3, 0};
      n_chk = 0;
      n_err = 0;
      reset = 1'b1;
      bus.fgi = 2'b00;
      bus.fgo = 2'b00;
      bus.imsk = 4'hF;
      bus.ien = 1'b1;
      bus.intr_ack = 1'b0;
      bus.insn_end = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();
      chk("rst_req",  32'(bus.intr_req), 32'd0);
      chk("rst_busy", 32'(bus.busy),     32'd0);

      // First request one edge after a flag appears
      bus.fgi = 2'b01;
      cycle();
      chk("t1_req",  32'(bus.intr_req), 32'd1);
      chk("t1_src",  32'(bus.src_id),   32'd0);
      chk("t1_iot",  32'(bus.iot),      32'd0);
      chk("t1_busy", 32'(bus.busy),     32'd1);

      // Rotation through all four sources
      bus.fgi = 2'b11;
      bus.fgo = 2'b11;
      for (int g = 0; g < 5; g++) begin
         wait_req(8);
         chk("t2_src", 32'(bus.src_id), 32'(order[g]));
         bus.intr_ack = 1'b1;
         cycle();
         bus.intr_ack = 1'b0;
         set_src(order[g], 1'b0);
         cycle();
         chk("t2_wait", 32'(bus.svc_done), 32'd0);
         bus.insn_end = 1'b1;
         cycle();
         bus.insn_end = 1'b0;
         chk("t2_done", 32'(bus.svc_done), 32'd1);
         set_src(order[g], 1'b1);
      end

      // Withdraw before ack leaves priority untouched
      bus.fgi = 2'b00;
      bus.fgo = 2'b00;
      do_reset();
      bus.fgi[1] = 1'b1;
      wait_req(8);
      chk("t3_src", 32'(bus.src_id), 32'd2);
      chk("t3_iot", 32'(bus.iot),    32'd1);
      bus.fgi[1] = 1'b0;
      cycle();
      chk("t3_req",  32'(bus.intr_req), 32'd0);
      chk("t3_busy", 32'(bus.busy),     32'd0);
      chk("t3_done", 32'(bus.svc_done), 32'd0);
      bus.fgi = 2'b11;
      bus.fgo = 2'b11;
      wait_req(8);
      chk("t3_next", 32'(bus.src_id), 32'd0);

      // Global enable low blocks all requests
      do_reset();
      bus.ien = 1'b0;
      repeat (100) cycle();
      chk("t4_req", 32'(bus.intr_req), 32'd0);
      bus.ien = 1'b1;
      wait_req(8);
      chk("t4_src", 32'(bus.src_id), 32'd0);

      // Stuck service: timeout build rotates on, default build keeps waiting
      bus.fgi = 2'b00;
      bus.fgo = 2'b00;
      do_reset();
      bus.fgo[0] = 1'b1;
      wait_req(8);
      chk("t5_src", 32'(bus.src_id), 32'd1);
      bus.intr_ack = 1'b1;
      cycle();
      bus.intr_ack = 1'b0;
      n = 0;
      while (bus.svc_tmo !== 1'b1 && n < 20) begin
         cycle();
         n++;
      end
`ifdef IO_INTR_TIMEOUT_EN
      chk("t5_tmo_delay", 32'(n), 32'd8);
      bus.fgi = 2'b11;
      bus.fgo = 2'b11;
      wait_req(8);
      chk("t5_next", 32'(bus.src_id), 32'd2);
`else
      chk("t5_no_tmo", 32'(n), 32'd20);
      chk("t5_busy",   32'(bus.busy), 32'd1);
      bus.fgo[0] = 1'b0;
      bus.insn_end = 1'b1;
      cycle();
      bus.insn_end = 1'b0;
      chk("t5_done", 32'(bus.svc_done), 32'd1);
`endif

      // Asynchronous reset in the middle of a service
      bus.fgi = 2'b00;
      bus.fgo = 2'b00;
      do_reset();
      bus.fgi[1] = 1'b1;
      wait_req(8);
      bus.intr_ack = 1'b1;
      cycle();
      bus.intr_ack = 1'b0;
      chk("t6_svc", 32'(bus.busy), 32'd1);
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("t6_req",  32'(bus.intr_req), 32'd0);
      chk("t6_busy", 32'(bus.busy),     32'd0);
      chk("t6_src",  32'(bus.src_id),   32'd0);
      chk("t6_iot",  32'(bus.iot),      32'd0);
      cycle();
      reset = 1'b0;
      bus.fgi = 2'b11;
      bus.fgo = 2'b11;
      wait_req(8);
      chk("t6_next", 32'(bus.src_id), 32'd0);

      // Randomised traffic against the model
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(7) == 0) bus.fgi[0] = ~bus.fgi[0];
         if ($urandom_range(7) == 0) bus.fgi[1] = ~bus.fgi[1];
         if ($urandom_range(7) == 0) bus.fgo[0] = ~bus.fgo[0];
         if ($urandom_range(7) == 0) bus.fgo[1] = ~bus.fgo[1];
         if ($urandom_range(63) == 0) bus.imsk = 4'($urandom_range(15));
         bus.ien      = ($urandom_range(15) != 0);
         bus.intr_ack = ($urandom_range(3) == 0);
         bus.insn_end = 1'($urandom_range(1));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
